hcsr04_emulator: RTL and testbench

Behavioural-synthesizable HC-SR04 ultrasonic sensor model: the responder end of the trig/echo protocol driven by the HC-SR04 controller. It watches `trig`, waits the sensor's burst delay, then drives `echo` high for a time proportional to a programmed distance in millimetres. It is used on-board and in simulation as a loopback target for the controller, so no physical sensor is needed.

---
 rtl/hcsr04_pkg.sv | 23 ++
 rtl/hcsr04_sync_edge.sv | 32 +++
 rtl/hcsr04_emulator.sv | 162 ++++++++++++++++
 tb/tb_hcsr04_emulator.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hcsr04_pkg.sv
// Shared HC-SR04 types and constants, imported by both the emulator and the controller.
// Holds the emulator state encoding, the valid distance range and the common counter width.
package hcsr04_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRIG,
        ST_BURST,
        ST_ECHO,
        ST_HOLD
    } hcsr04_emu_state_t;

    localparam int unsigned DIST_MIN_MM  = 20;
    localparam int unsigned DIST_MAX_MM  = 4000;
    localparam int unsigned HCSR04_CNT_W = 22;

    typedef logic [HCSR04_CNT_W-1:0] hcsr04_cnt_t;

    function automatic logic dist_in_range(input logic [11:0] mm);
        return (mm >= 12'(DIST_MIN_MM)) && (mm <= 12'(DIST_MAX_MM));
    endfunction

endpackage

// File: rtl/hcsr04_sync_edge.sv
// 2-FF synchroniser for an asynchronous level, with registered rise/fall pulses.
// Latency: pulses fire one cycle after the synchronised level changes.
// Backpressure: none; free-running, one pulse per synchronised edge.
module hcsr04_sync_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    // [1:0] is the synchroniser; [2] is the previous synchronised value.
    logic [2:0] sync_q;
    logic       rise_q;
    logic       fall_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            sync_q <= '0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[1:0], d_i};
            rise_q <= sync_q[1] & ~sync_q[2];
            fall_q <= ~sync_q[1] & sync_q[2];
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/hcsr04_emulator.sv
// HC-SR04 responder: trig in, echo pulse of distance*CYC_PER_MM cycles (or TIMEOUT_CYC) out.
// Latency: echo rises BURST_DLY_CYC cycles after the synchronised trig falls.
// Backpressure: none; trig is ignored while busy. Short-trig rejection: HCSR04_EMU_TRIG_CHECK_EN.
module hcsr04_emulator
    import hcsr04_pkg::*;
#(
`ifdef HCSR04_EMU_TRIG_CHECK_EN
    parameter int unsigned TRIG_MIN_CYC  = 1000,
`endif
    parameter int unsigned CYC_PER_MM    = 583,
    parameter int unsigned BURST_DLY_CYC = 20000,
    parameter int unsigned TIMEOUT_CYC   = 3800000,
    parameter int unsigned HOLDOFF_CYC   = 1000000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        trig_i,
    input  logic [11:0] distance_i,
    output logic        echo_o,
    output logic        busy_o,
    output logic        trig_err_o
);

    localparam hcsr04_cnt_t CNT_ONE   = hcsr04_cnt_t'(1);
    localparam hcsr04_cnt_t BURST_LD  = hcsr04_cnt_t'(2);
    localparam hcsr04_cnt_t BURST_END = hcsr04_cnt_t'(BURST_DLY_CYC - 1);
    localparam hcsr04_cnt_t SUB_END   = hcsr04_cnt_t'(CYC_PER_MM - 1);
    localparam hcsr04_cnt_t TOUT_END  = hcsr04_cnt_t'(TIMEOUT_CYC - 1);
    localparam hcsr04_cnt_t HOLD_END  = hcsr04_cnt_t'(HOLDOFF_CYC - 1);

    logic trig_rise;
    logic trig_fall;

    hcsr04_sync_edge u_sync (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .d_i    (trig_i),
        .rise_o (trig_rise),
        .fall_o (trig_fall)
    );

    hcsr04_emu_state_t state_q, state_d;
    hcsr04_cnt_t       cnt_q, cnt_d;
    logic [11:0]       mm_q, mm_d;
    logic              rng_q, rng_d;
    logic              echo_q, echo_d;
`ifdef HCSR04_EMU_TRIG_CHECK_EN
    logic              trig_err_q, trig_err_d;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            mm_q       <= '0;
            rng_q      <= 1'b0;
            echo_q     <= 1'b0;
`ifdef HCSR04_EMU_TRIG_CHECK_EN
            trig_err_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mm_q       <= mm_d;
            rng_q      <= rng_d;
            echo_q     <= echo_d;
`ifdef HCSR04_EMU_TRIG_CHECK_EN
            trig_err_q <= trig_err_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mm_d       = mm_q;
        rng_d      = rng_q;
        echo_d     = echo_q;
`ifdef HCSR04_EMU_TRIG_CHECK_EN
        trig_err_d = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (trig_rise) begin
                    state_d = ST_TRIG;
`ifdef HCSR04_EMU_TRIG_CHECK_EN
                    cnt_d   = CNT_ONE;
`endif
                end
            end
            ST_TRIG: begin
                if (trig_fall) begin
                    // Fall pulse trails the synchronised level by one cycle, so BURST starts at 2.
                    state_d = ST_BURST;
                    cnt_d   = BURST_LD;
                    mm_d    = distance_i;
                    rng_d   = dist_in_range(distance_i);
`ifdef HCSR04_EMU_TRIG_CHECK_EN
                    if (cnt_q < hcsr04_cnt_t'(TRIG_MIN_CYC)) begin
                        state_d    = ST_IDLE;
                        trig_err_d = 1'b1;
                    end
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_ONE;
`endif
                end
            end
            ST_BURST: begin
                if (cnt_q == BURST_END) begin
                    state_d = ST_ECHO;
                    cnt_d   = '0;
                    echo_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_ECHO: begin
                // In range, cnt_q is the per-mm sub-counter; otherwise it counts the timeout.
                if (rng_q) begin
                    if (cnt_q == SUB_END) begin
                        cnt_d = '0;
                        mm_d  = mm_q - 12'd1;
                        if (mm_q == 12'd1) begin
                            state_d = ST_HOLD;
                            echo_d  = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else if (cnt_q == TOUT_END) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                    echo_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_HOLD: begin
                if (cnt_q == HOLD_END) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                echo_d  = 1'b0;
            end
        endcase
    end

    assign echo_o = echo_q;
    assign busy_o = (state_q != ST_IDLE);
`ifdef HCSR04_EMU_TRIG_CHECK_EN
    assign trig_err_o = trig_err_q;
`else
    assign trig_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_hcsr04_emulator.sv
// Scoreboard bench for hcsr04_emulator with shortened timing parameters.
// Expected echo widths are queued at trigger time and popped when the echo pulse ends.
`timescale 1ns/1ps
module tb_hcsr04_emulator;

    localparam int CPM     = 2;
    localparam int BDLY    = 50;
    localparam int TOUT    = 10000;
    localparam int HOLD    = 300;
    localparam int LIM     = TOUT + 1000;
    localparam int SHORT_W = 5;
`ifdef HCSR04_EMU_TRIG_CHECK_EN
    localparam int TMIN    = 10;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        trig;
    logic [11:0] distance;
    logic        echo;
    logic        busy;
    logic        trig_err;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];
    int echo_rises = 0;
    int err_pulses = 0;
    logic echo_prev = 1'b0;

    hcsr04_emulator #(
`ifdef HCSR04_EMU_TRIG_CHECK_EN
        .TRIG_MIN_CYC  (TMIN),
`endif
        .CYC_PER_MM    (CPM),
        .BURST_DLY_CYC (BDLY),
        .TIMEOUT_CYC   (TOUT),
        .HOLDOFF_CYC   (HOLD)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .trig_i     (trig),
        .distance_i (distance),
        .echo_o     (echo),
        .busy_o     (busy),
        .trig_err_o (trig_err)
    );

    initial forever #5 clk = ~clk;

    always @(negedge clk) begin
        if (echo === 1'b1 && echo_prev !== 1'b1) echo_rises++;
        if (trig_err === 1'b1) err_pulses++;
        echo_prev = echo;
    end

    function automatic int exp_width(input int d);
        return (d >= 20 && d <= 4000) ? d * CPM : TOUT;
    endfunction

    task automatic pulse_trig(input int hi);
        @(negedge clk);
        trig = 1'b1;
        repeat (hi) @(negedge clk);
        trig = 1'b0;
    endtask

    // Cycles from trig fall to echo rise, then echo high width; both bounded by LIM.
    task automatic measure(output int lat, output int wid);
        lat = 0;
        wid = 0;
        while (echo !== 1'b1 && lat < LIM) begin
            @(negedge clk);
            lat++;
        end
        while (echo === 1'b1 && wid < LIM) begin
            @(negedge clk);
            wid++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        trig = 1'b0;
        distance = 12'd0;
        repeat (3) @(negedge clk);
        checks++; if (echo !== 1'b0) begin failures++; $display("FAIL reset_echo got=%b exp=0", echo); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (trig_err !== 1'b0) begin failures++; $display("FAIL reset_trig_err got=%b exp=0", trig_err); end
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_measure_85();
        int lat, wid, exp;
        distance = 12'd85;
        exp_q.push_back(85 * CPM);
        pulse_trig(20);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL m85_busy_after_trig got=%b exp=1", busy); end
        measure(lat, wid);
        exp = exp_q.pop_front();
        checks++; if (wid !== exp) begin failures++; $display("FAIL m85_width got=%0d exp=%0d", wid, exp); end
        checks++; if (lat < BDLY + 1 || lat > BDLY + 3) begin failures++; $display("FAIL m85_latency got=%0d exp=%0d+-1", lat, BDLY + 2); end
        repeat (HOLD - 1) @(negedge clk);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL m85_busy_before_holdoff_end got=%b exp=1", busy); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL m85_busy_after_holdoff got=%b exp=0", busy); end
    endtask

    task automatic test_range();
        int dists[5];
        int lat, wid, exp;
        dists = '{4000, 4001, 0, 20, 19};
        foreach (dists[i]) begin
            distance = 12'(dists[i]);
            exp_q.push_back(exp_width(dists[i]));
            pulse_trig(20);
            measure(lat, wid);
            exp = exp_q.pop_front();
            checks++; if (wid !== exp) begin failures++; $display("FAIL range_width d=%0d got=%0d exp=%0d", dists[i], wid, exp); end
            checks++; if (lat < BDLY + 1 || lat > BDLY + 3) begin failures++; $display("FAIL range_latency d=%0d got=%0d exp=%0d+-1", dists[i], lat, BDLY + 2); end
            repeat (HOLD + 5) @(negedge clk);
        end
    endtask

    task automatic test_short_trig();
        int base_rise, base_err;
`ifndef HCSR04_EMU_TRIG_CHECK_EN
        int lat, wid, exp;
`endif
        base_rise = echo_rises;
        base_err  = err_pulses;
        distance  = 12'd85;
`ifdef HCSR04_EMU_TRIG_CHECK_EN
        pulse_trig(SHORT_W);
        repeat (6) @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL short_busy got=%b exp=0", busy); end
        repeat (BDLY + 20) @(negedge clk);
        checks++; if (err_pulses - base_err != 1) begin failures++; $display("FAIL short_err_pulses got=%0d exp=1", err_pulses - base_err); end
        checks++; if (echo_rises != base_rise) begin failures++; $display("FAIL short_no_echo got=%0d exp=0", echo_rises - base_rise); end
`else
        exp_q.push_back(85 * CPM);
        pulse_trig(SHORT_W);
        measure(lat, wid);
        exp = exp_q.pop_front();
        checks++; if (wid !== exp) begin failures++; $display("FAIL short_width got=%0d exp=%0d", wid, exp); end
        checks++; if (echo_rises - base_rise != 1) begin failures++; $display("FAIL short_echo_count got=%0d exp=1", echo_rises - base_rise); end
        checks++; if (err_pulses != base_err) begin failures++; $display("FAIL short_err_pulses got=%0d exp=0", err_pulses - base_err); end
        repeat (HOLD + 5) @(negedge clk);
`endif
    endtask

    task automatic test_ignored_trig();
        int lat, wid, exp, base;
        base = echo_rises;
        distance = 12'd85;
        exp_q.push_back(85 * CPM);
        pulse_trig(20);
        repeat (10) @(negedge clk);
        distance = 12'd300;
        lat = 10;
        while (echo !== 1'b1 && lat < LIM) begin
            @(negedge clk);
            lat++;
        end
        wid = 0;
        while (echo === 1'b1 && wid < LIM) begin
            if (wid == 20) trig = 1'b1;
            if (wid == 50) trig = 1'b0;
            @(negedge clk);
            wid++;
        end
        trig = 1'b0;
        exp = exp_q.pop_front();
        checks++; if (wid !== exp) begin failures++; $display("FAIL ignored_width got=%0d exp=%0d", wid, exp); end
        repeat (HOLD + BDLY + 20) @(negedge clk);
        checks++; if (echo_rises - base != 1) begin failures++; $display("FAIL ignored_echo_count got=%0d exp=1", echo_rises - base); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ignored_busy_idle got=%b exp=0", busy); end
        distance = 12'd85;
    endtask

    task automatic test_mid_echo_reset();
        int lat, wid, exp, n;
        distance = 12'd85;
        pulse_trig(20);
        n = 0;
        while (echo !== 1'b1 && n < LIM) begin
            @(negedge clk);
            n++;
        end
        checks++; if (echo !== 1'b1) begin failures++; $display("FAIL rst_echo_started got=%b exp=1", echo); end
        repeat (30) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        checks++; if (echo !== 1'b0) begin failures++; $display("FAIL rst_mid_echo got=%b exp=0", echo); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
        repeat (9) @(negedge clk);
        exp_q.push_back(85 * CPM);
        pulse_trig(20);
        measure(lat, wid);
        exp = exp_q.pop_front();
        checks++; if (wid !== exp) begin failures++; $display("FAIL rst_after_width got=%0d exp=%0d", wid, exp); end
        checks++; if (lat < BDLY + 1 || lat > BDLY + 3) begin failures++; $display("FAIL rst_after_latency got=%0d exp=%0d+-1", lat, BDLY + 2); end
        repeat (HOLD + 5) @(negedge clk);
    endtask

    task automatic test_holdoff();
        int lat, wid, exp, base;
        distance = 12'd85;
        exp_q.push_back(85 * CPM);
        pulse_trig(20);
        measure(lat, wid);
        exp = exp_q.pop_front();
        checks++; if (wid !== exp) begin failures++; $display("FAIL hold_first_width got=%0d exp=%0d", wid, exp); end
        base = echo_rises;
        repeat (100) @(negedge clk);
        pulse_trig(20);
        repeat (BDLY + 20) @(negedge clk);
        checks++; if (echo_rises != base) begin failures++; $display("FAIL hold_trig_ignored got=%0d exp=0", echo_rises - base); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL hold_still_busy got=%b exp=1", busy); end
        // Trig held high across the end of holdoff must not start a measurement.
        repeat (80) @(negedge clk);
        trig = 1'b1;
        repeat (60) @(negedge clk);
        trig = 1'b0;
        repeat (BDLY + 20) @(negedge clk);
        checks++; if (echo_rises != base) begin failures++; $display("FAIL hold_level_trig got=%0d exp=0", echo_rises - base); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL hold_level_busy got=%b exp=0", busy); end
        exp_q.push_back(85 * CPM);
        pulse_trig(20);
        measure(lat, wid);
        exp = exp_q.pop_front();
        checks++; if (wid !== exp) begin failures++; $display("FAIL hold_after_width got=%0d exp=%0d", wid, exp); end
        checks++; if (echo_rises - base != 1) begin failures++; $display("FAIL hold_after_count got=%0d exp=1", echo_rises - base); end
        repeat (HOLD + 5) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_measure_85();
        test_range();
        test_short_trig();
        test_ignored_trig();
        test_mid_echo_reset();
        test_holdoff();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
